cam_pixel_writer: RTL and testbench
===================================

Name: cam_pixel_writer

Overview:
- Frame-aligned write stage between the OV7670 byte stream and the frame-buffer BRAM write port.
- Assembles RGB565 byte pairs into pixels and converts each to 12-bit RGB444 or to 4-bit gray replicated to 12 bits.
- Generates linear write addresses, aligns capture to VSYNC, and flags malformed lines.
- Replaces direct byte-to-BRAM writes in the camera top level.

Parameters:
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- ADDR_W, 19: BRAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- PIX_FMT, 0: output format. 0 = RGB444 {R[4:1],G[5:2],B[4:1]}; 1 = GRAY4 replicated {Y,Y,Y}.

Ports:
- pclk, input, 1: camera pixel clock; the only clock.
- reset, input, 1: synchronous, active-high.
- config_done, input, 1: SCCB configuration complete.
- cam_vsync, input, 1: frame sync; high between frames.
- cam_href, input, 1: line valid.
- cam_data, input, 8: pixel byte.
- bram_addr, output, ADDR_W: write address.
- bram_din, output, 12: write data.
- bram_we, output, 1: write enable.
- frame_active, output, 1: capture in progress.
- frame_done, output, 1: one-cycle pulse at a clean frame end.
- line_err, output, 1: sticky per frame; some line had pixel count != H_ACTIVE.
- phase_err, output, 1: sticky per frame; a line ended on an odd byte.

Behaviour:
- All inputs are sampled on the pclk rising edge. All outputs are registered.
- Reset values: every output is 0; state is WAIT_CFG; all counters are 0; byte phase is 0.
- State WAIT_CFG: go to WAIT_SOF when config_done=1.
- State WAIT_SOF: go to CAPTURE when cam_vsync falls (sampled 1 then 0). This guarantees a partial frame is never captured.
  - On entry to CAPTURE: clear x, y, line_base, line_err and phase_err; set frame_active=1.
- State CAPTURE:
  - Each cycle with cam_href=1, toggle the byte phase.
  - Phase 0: latch the high byte {R5,G6[5:3]}.
  - Phase 1: combine with the low byte {G6[2:0],B5} to form the pixel.
  - Pixel write: on the cycle after phase-1 sampling, assert bram_we=1 for exactly one cycle with bram_addr = line_base + x and bram_din = the converted pixel.
  - Latency is 1 pclk from the second byte to bram_we.
  - Counter x increments per pixel. Writes are suppressed (bram_we=0, x still counts) when x >= H_ACTIVE or y >= V_ACTIVE.
  - On the cam_href falling edge:
    - If phase=1, set phase_err and discard the half pixel.
    - If x != H_ACTIVE, set line_err.
    - Then x := 0, phase := 0, y := y+1, line_base := line_base + H_ACTIVE.
    - line_base saturates once y >= V_ACTIVE, so no address ever exceeds H_ACTIVE*V_ACTIVE-1.
  - On a cam_vsync rising edge:
    - Go to WAIT_SOF and clear frame_active.
    - Pulse frame_done only if y == V_ACTIVE and no error flag is set.
    - Error flags hold their value until the next CAPTURE entry.
  - cam_vsync rising while cam_href=1: treat as a frame end as above. Discard any pending half pixel and apply no line_err check to that truncated line.
- config_done falling in any state: go to WAIT_CFG next cycle, bram_we=0, frame_active=0, no frame_done.
- Reset asserted mid-frame: all outputs are 0 on the next cycle and any pending write is dropped.
- Gray conversion:
  - r6 = {R5,R5[4]}, b6 = {B5,B5[4]}.
  - Y6 = (2*r6 + 5*G6 + b6) >> 3, using a 9-bit intermediate with a maximum of 504. Y6 never exceeds 63.
  - Y4 = Y6[5:2].

Decomposition:
- Package cam_pkg holds:
  - default H_ACTIVE and V_ACTIVE constants;
  - PIX_FMT_RGB444 and PIX_FMT_GRAY4 constants;
  - typedef enum cap_state_t {WAIT_CFG, WAIT_SOF, CAPTURE}.
- Sub-module rgb565_convert: purely combinational; 16-bit RGB565 plus format select to 12-bit out. The registered stage lives in cam_pixel_writer.

Test Plan:
- Config gating: config_done=0 with a full frame driven -> bram_we never asserts. Raise config_done mid-frame -> the first write occurs only after the next vsync fall, at addr 0.
- Nominal frame with H_ACTIVE=4, V_ACTIVE=2 and bytes 0xF8,0x00 (pure red) -> 8 writes, addr 0..7, din 0xF00 in RGB444. With PIX_FMT=1, din 0x333 (Y6=15). Then frame_done pulses exactly once, 1 cycle after vsync rises.
- Bytes 0xFF,0xFF with PIX_FMT=1 -> din 0xFFF. Bytes 0x00,0x00 -> din 0x000.
- Short line (3 pixels) then odd byte count (7 bytes) -> line_err=1 and phase_err=1; no frame_done; second line still starts at addr 4; flags clear on next frame start.
- Extra line (3 lines with V_ACTIVE=2) -> no write at addr >= 8; no frame_done since y != V_ACTIVE.
- Reset pulsed between the two bytes of a pixel -> no write for that pixel; outputs 0 next cycle; FSM in WAIT_CFG.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and state type for the camera capture path.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int PIX_FMT_RGB444 = 0;
    localparam int PIX_FMT_GRAY4  = 1;

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/rgb565_convert.sv
// Combinational RGB565 to 12-bit pixel conversion (RGB444, or 4-bit gray replicated).
module rgb565_convert (
    input  logic [15:0] pix,
    input  logic        gray,
    output logic [11:0] rgb
);

    function automatic logic [11:0] to_rgb444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    // Weights 2:5:1 over 8; the 9-bit sum tops out at 504, so Y6[5:2] is sum[8:5].
    function automatic logic [3:0] to_gray4(input logic [15:0] p);
        logic [5:0] r6;
        logic [5:0] g6;
        logic [5:0] b6;
        logic [8:0] sum;
        r6  = {p[15:11], p[15]};
        g6  = p[10:5];
        b6  = {p[4:0], p[4]};
        sum = {2'b00, r6, 1'b0} + {1'b0, g6, 2'b00} + {3'b000, g6} + {3'b000, b6};
        return sum[8:5];
    endfunction

    logic [3:0] y4;

    always_comb begin
        y4  = to_gray4(pix);
        rgb = gray ? {y4, y4, y4} : to_rgb444(pix);
    end

endmodule

// File: rtl/cam_pixel_writer.sv
// Frame-aligned OV7670 byte-pair assembler producing linear frame-buffer writes.
module cam_pixel_writer
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 19,
    parameter int PIX_FMT  = PIX_FMT_RGB444
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              config_done,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [11:0]       bram_din,
    output logic              bram_we,
    output logic              frame_active,
    output logic              frame_done,
    output logic              line_err,
    output logic              phase_err
);

    localparam int X_W = $clog2(H_ACTIVE + 1) + 1;
    localparam int Y_W = $clog2(V_ACTIVE + 1) + 1;
    localparam logic [X_W-1:0]    X_LIM     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    cap_state_t state, state_nxt;

    logic              vsync_d;
    logic              href_d;
    logic              phase, phase_nxt;
    logic [7:0]        hi_p0, hi_nxt;
    logic [X_W-1:0]    x, x_nxt;
    logic [Y_W-1:0]    y, y_nxt;
    logic [ADDR_W-1:0] line_base, line_base_nxt;

    logic [ADDR_W-1:0] addr_nxt;
    logic [11:0]       din_nxt;
    logic              we_nxt;
    logic              active_nxt;
    logic              done_nxt;
    logic              line_err_nxt;
    logic              phase_err_nxt;

    logic [11:0]       pix_cvt;
    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_fall;

    assign vsync_rise = cam_vsync & ~vsync_d;
    assign vsync_fall = ~cam_vsync & vsync_d;
    assign href_fall  = ~cam_href & href_d;

    rgb565_convert u_convert (
        .pix  ({hi_p0, cam_data}),
        .gray (PIX_FMT == PIX_FMT_GRAY4),
        .rgb  (pix_cvt)
    );

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        hi_nxt        = hi_p0;
        x_nxt         = x;
        y_nxt         = y;
        line_base_nxt = line_base;
        addr_nxt      = bram_addr;
        din_nxt       = bram_din;
        we_nxt        = 1'b0;
        active_nxt    = frame_active;
        done_nxt      = 1'b0;
        line_err_nxt  = line_err;
        phase_err_nxt = phase_err;

        if (!config_done) begin
            state_nxt  = WAIT_CFG;
            active_nxt = 1'b0;
            phase_nxt  = 1'b0;
        end else begin
            case (state)
                WAIT_CFG: state_nxt = WAIT_SOF;

                // Only a vsync fall seen here starts a frame, so a partial frame is skipped.
                WAIT_SOF: begin
                    if (vsync_fall) begin
                        state_nxt     = CAPTURE;
                        x_nxt         = '0;
                        y_nxt         = '0;
                        line_base_nxt = '0;
                        line_err_nxt  = 1'b0;
                        phase_err_nxt = 1'b0;
                        phase_nxt     = 1'b0;
                        active_nxt    = 1'b1;
                    end
                end

                CAPTURE: begin
                    if (vsync_rise) begin
                        // Frame end wins over any byte on this cycle; a half pixel is dropped.
                        state_nxt  = WAIT_SOF;
                        active_nxt = 1'b0;
                        phase_nxt  = 1'b0;
                        done_nxt   = (y == Y_LIM) && !line_err && !phase_err;
                    end else if (cam_href) begin
                        if (!phase) begin
                            hi_nxt    = cam_data;
                            phase_nxt = 1'b1;
                        end else begin
                            phase_nxt = 1'b0;
                            x_nxt     = (x == '1) ? x : x + X_W'(1);
                            if (x < X_LIM && y < Y_LIM) begin
                                we_nxt   = 1'b1;
                                addr_nxt = line_base + ADDR_W'(x);
                                din_nxt  = pix_cvt;
                            end
                        end
                    end else if (href_fall) begin
                        if (phase) phase_err_nxt = 1'b1;
                        if (x != X_LIM) line_err_nxt = 1'b1;
                        x_nxt     = '0;
                        phase_nxt = 1'b0;
                        y_nxt     = (y == '1) ? y : y + Y_W'(1);
                        // Base stops at the last line so addresses stay inside the frame.
                        if (y_nxt < Y_LIM) line_base_nxt = line_base + LINE_STEP;
                    end
                end

                default: state_nxt = WAIT_CFG;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state        <= WAIT_CFG;
            vsync_d      <= 1'b0;
            href_d       <= 1'b0;
            phase        <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_base    <= '0;
            bram_addr    <= '0;
            bram_din     <= '0;
            bram_we      <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            line_err     <= 1'b0;
            phase_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            vsync_d      <= cam_vsync;
            href_d       <= cam_href;
            phase        <= phase_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            line_base    <= line_base_nxt;
            bram_addr    <= addr_nxt;
            bram_din     <= din_nxt;
            bram_we      <= we_nxt;
            frame_active <= active_nxt;
            frame_done   <= done_nxt;
            line_err     <= line_err_nxt;
            phase_err    <= phase_err_nxt;
        end
    end

    // High-byte latch is pure data and is qualified by phase, so it needs no reset.
    always_ff @(posedge pclk) begin
        hi_p0 <= hi_nxt;
    end

endmodule

// File: tb/tb_cam_pixel_writer.sv
// Directed and randomized frame bench for cam_pixel_writer, RGB444 and GRAY4 side by side.
module tb_cam_pixel_writer;
    import cam_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;

    logic          pclk = 1'b0;
    logic          reset;
    logic          config_done;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;

    logic [AW-1:0] addr_rgb, addr_gry;
    logic [11:0]   din_rgb, din_gry;
    logic          we_rgb, we_gry;
    logic          active_rgb, active_gry;
    logic          done_rgb, done_gry;
    logic          lerr_rgb, lerr_gry;
    logic          perr_rgb, perr_gry;

    int total = 0;
    int passed = 0;
    int exp_rgb[$];
    int exp_gry[$];
    int obs_rgb[$];
    int obs_gry[$];
    int ndone_rgb = 0;
    int ndone_gry = 0;
    bit cap = 1'b0;

    always #5 pclk = ~pclk;

    cam_pixel_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_FMT(PIX_FMT_RGB444)) dut_rgb (
        .pclk(pclk), .reset(reset), .config_done(config_done),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .bram_addr(addr_rgb), .bram_din(din_rgb), .bram_we(we_rgb),
        .frame_active(active_rgb), .frame_done(done_rgb),
        .line_err(lerr_rgb), .phase_err(perr_rgb)
    );

    cam_pixel_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_FMT(PIX_FMT_GRAY4)) dut_gry (
        .pclk(pclk), .reset(reset), .config_done(config_done),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .bram_addr(addr_gry), .bram_din(din_gry), .bram_we(we_gry),
        .frame_active(active_gry), .frame_done(done_gry),
        .line_err(lerr_gry), .phase_err(perr_gry)
    );

    always @(negedge pclk) begin
        if (we_rgb) obs_rgb.push_back(int'(addr_rgb) * 4096 + int'(din_rgb));
        if (we_gry) obs_gry.push_back(int'(addr_gry) * 4096 + int'(din_gry));
        if (done_rgb) ndone_rgb++;
        if (done_gry) ndone_gry++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    function automatic int ref_pix(input int p, input bit gray);
        int r, g, b, r6, b6, y4;
        r = (p >> 11) & 31;
        g = (p >> 5) & 63;
        b = p & 31;
        if (!gray) return ((r / 2) << 8) | ((g / 4) << 4) | (b / 2);
        r6 = r * 2 + r / 16;
        b6 = b * 2 + b / 16;
        y4 = ((2 * r6 + 5 * g + b6) / 8) / 4;
        return y4 * 'h111;
    endfunction

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_q();
        exp_rgb.delete();
        exp_gry.delete();
        obs_rgb.delete();
        obs_gry.delete();
        ndone_rgb = 0;
        ndone_gry = 0;
    endtask

    task automatic send_line(input int lidx, input int nbytes, input int hb, input int lb, input bit rnd);
        int hi, v, k;
        hi = 0;
        for (int i = 0; i < nbytes; i++) begin
            if (rnd) v = int'($urandom_range(0, 255));
            else v = (i % 2 == 0) ? hb : lb;
            if (i % 2 == 0) hi = v;
            else begin
                k = i / 2;
                if (cap && lidx < V && k < H) begin
                    exp_rgb.push_back((lidx * H + k) * 4096 + ref_pix(hi * 256 + v, 1'b0));
                    exp_gry.push_back((lidx * H + k) * 4096 + ref_pix(hi * 256 + v, 1'b1));
                end
            end
            cyc(1'b0, 1'b1, 8'(v));
        end
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr_rgb"}, obs_rgb.size(), exp_rgb.size());
        chk({tag, "_nwr_gry"}, obs_gry.size(), exp_gry.size());
        for (int i = 0; i < obs_rgb.size() && i < exp_rgb.size(); i++)
            chk({tag, "_wr_rgb"}, obs_rgb[i], exp_rgb[i]);
        for (int i = 0; i < obs_gry.size() && i < exp_gry.size(); i++)
            chk({tag, "_wr_gry"}, obs_gry[i], exp_gry[i]);
    endtask

    task automatic send_frame(input string tag, input int nl, input int nb0, input int nb1,
                              input int hb, input int lb, input bit rnd);
        int  nb;
        bit  el, ep, ed;
        el = 1'b0;
        ep = 1'b0;
        clear_q();
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        chk({tag, "_active"}, active_rgb, cap);
        if (cap) chk({tag, "_flags_clr"}, {lerr_rgb, perr_rgb, lerr_gry, perr_gry}, 0);
        for (int l = 0; l < nl; l++) begin
            nb = (l == 0) ? nb0 : nb1;
            if (nb % 2 != 0) ep = 1'b1;
            if (nb / 2 != H) el = 1'b1;
            send_line(l, nb, hb, lb, rnd);
        end
        ed = cap && (nl == V) && !el && !ep;
        cyc(1'b1, 1'b0, 8'h00);
        chk({tag, "_done_rgb"}, done_rgb, ed);
        chk({tag, "_done_gry"}, done_gry, ed);
        cyc(1'b1, 1'b0, 8'h00);
        chk({tag, "_done_low"}, done_rgb, 0);
        chk({tag, "_inactive"}, active_rgb, 0);
        chk({tag, "_ndone"}, ndone_rgb + ndone_gry, ed ? 2 : 0);
        if (cap) begin
            chk({tag, "_line_err"}, {lerr_rgb, lerr_gry}, {el, el});
            chk({tag, "_phase_err"}, {perr_rgb, perr_gry}, {ep, ep});
        end
        cmp_writes(tag);
    endtask

    initial begin
        reset       = 1'b1;
        config_done = 1'b0;
        cam_vsync   = 1'b1;
        cam_href    = 1'b0;
        cam_data    = 8'h00;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_outs", {we_rgb, active_rgb, done_rgb, lerr_rgb, perr_rgb, we_gry, active_gry},
            0);
        chk("rst_addr", addr_rgb, 0);
        chk("rst_din", {din_rgb, din_gry}, 0);
        reset = 1'b0;

        // Unconfigured sensor: a whole frame must produce nothing.
        cap = 1'b0;
        send_frame("gate", 2, 8, 8, 'hF8, 'h00, 1'b0);

        // Configuration completes mid-frame: that frame is still skipped.
        clear_q();
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        send_line(0, 8, 'hF8, 'h00, 1'b0);
        config_done = 1'b1;
        send_line(1, 8, 'hF8, 'h00, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        cmp_writes("cfg_mid");
        chk("cfg_mid_ndone", ndone_rgb, 0);

        cap = 1'b1;
        send_frame("red", 2, 8, 8, 'hF8, 'h00, 1'b0);
        send_frame("white", 2, 8, 8, 'hFF, 'hFF, 1'b0);
        send_frame("black", 2, 8, 8, 'h00, 'h00, 1'b0);
        repeat (3) send_frame("rand", 2, 8, 8, 0, 0, 1'b1);
        send_frame("err", 2, 6, 7, 'hF8, 'h00, 1'b0);
        send_frame("green", 2, 8, 8, 'h07, 'hE0, 1'b0);
        send_frame("extra", 3, 8, 8, 0, 0, 1'b1);

        // Reset between the two bytes of a pixel.
        clear_q();
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        chk("mid_rst_active", active_rgb, 1);
        cyc(1'b0, 1'b1, 8'h12);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h34);
        chk("mid_rst_outs", {we_rgb, active_rgb, done_rgb, lerr_rgb, perr_rgb, we_gry, active_gry},
            0);
        chk("mid_rst_addr_din", {addr_rgb, din_rgb, din_gry}, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'h56);
        cyc(1'b0, 1'b1, 8'h78);
        cyc(1'b0, 1'b0, 8'h00);
        chk("post_rst_idle", {we_rgb, active_rgb}, 0);
        cmp_writes("mid_rst");
        cyc(1'b1, 1'b0, 8'h00);
        send_frame("post_rst", 2, 8, 8, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
